group_mult_window: RTL and testbench
====================================

Name: group_mult_window

Overview:
- Upstream neighbour of the pipelined group adder.
- Accepts a scalar sample stream with valid/ready and keeps a sliding window of GROUP_NB samples per frame.
- Multiplies each window lane by a programmable fixed-point coefficient and presents the GROUP_NB products, concatenated, as the adder's input vector with a valid/last qualifier.
- Coefficients are written through a small config port while the block is idle.

Parameters:
GROUP_NB, 3, window length / number of lanes; must be >= 2, otherwise elaboration error ($display + $finish)
NUM_WIDTH, 16, signed sample, coefficient and product-lane width
FRAC_BITS, 8, fractional bits of coefficients; 0 <= FRAC_BITS < NUM_WIDTH

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  coefficient write request
cfg_ready  output  1  write accepted when cfg_valid & cfg_ready
cfg_addr  input  $clog2(GROUP_NB)  lane index to write
cfg_data  input  NUM_WIDTH  signed coefficient
up_data  input  NUM_WIDTH  signed sample
up_valid  input  1  sample valid
up_last  input  1  last sample of frame, qualified by up_valid
up_ready  output  1  block accepts sample
dn_data  output  NUM_WIDTH*GROUP_NB  products; lane i at [i*NUM_WIDTH +: NUM_WIDTH]
dn_valid  output  1  dn_data valid, single-cycle per output, no backpressure
dn_last  output  1  qualifies the final output of a frame

Behaviour:
Reset values:
- cfg_ready=0, up_ready=0, dn_valid=0, dn_last=0, dn_data=0.
- Window cleared, fill counter 0.
- All coefficients = 1<<FRAC_BITS (unity).
- Pipeline valid bits cleared.

Window (stage 1):
- A sample is accepted on the edge where up_valid & up_ready.
- Window shifts: lane 0 = oldest, lane GROUP_NB-1 = newest.
- Fill counter saturates at GROUP_NB.
- Stage-1 valid set only when this accept brings the fill count to GROUP_NB (or it is already there).

Stage 2: products p_i = window_i * coef_i, full 2*NUM_WIDTH signed, registered.

Stage 3:
- Lane result = p_i >>> FRAC_BITS (arithmetic), truncated to the low NUM_WIDTH bits (wrap).
- Registered into dn_data.

Latency:
- Sample accepted on edge k -> dn_valid high for the cycle after edge k+2.
- Full throughput: one output per accepted sample once filled.

Frame end:
- up_last accepted -> fill counter and window cleared on the same edge, after the window update used for that sample's output.
- The output derived from that sample carries dn_last=1.
- Short frame (fewer than GROUP_NB samples): no dn_valid, no dn_last; window cleared.

Handshake:
- up_ready = !rst_d & !(cfg_valid & cfg_ready). Here rst_d is rst registered one cycle, so up_ready=0 in the first cycle after reset.
- cfg_ready = 1 only when idle: fill counter 0 and all three stage valid bits 0, and not in reset.
- cfg_valid together with up_valid while idle: config write wins, sample not accepted that cycle.
- Coefficient updates take effect for samples accepted after the write edge.
- cfg_addr >= GROUP_NB: write accepted and ignored.

Reset mid-frame: all pipeline contents dropped. No dn_valid on the cycle after the reset edge. Coefficients return to unity.

dn_data holds its last value while dn_valid=0.

Optional Feature:
GROUP_MULT_SAT_EN:
- When defined, stage 3 saturates (p_i >>> FRAC_BITS) to [-2^(NUM_WIDTH-1), 2^(NUM_WIDTH-1)-1] instead of wrapping.
- Latency unchanged.
- When not defined, results wrap (two's-complement truncation).

Test Plan:
- Reset, unity coefs, NUM_WIDTH=16, FRAC_BITS=8; stream 10,20,30,40 (last on 40) back-to-back -> two outputs on consecutive cycles: {10,20,30} dn_last=0, then {20,30,40} dn_last=1 (lane0 first). First output 2 cycles after the 30 is accepted.
- Idle write lane1 = -512 (-2.0), then stream 1,2,3 last -> single output {1,-4,3} with dn_last=1. Write with cfg_valid & up_valid at the same time -> sample stalled exactly one cycle.
- Write lane2 = 0x7FFF, stream 0,0,1000 last -> lane2 = -3076 (wrap). With GROUP_MULT_SAT_EN -> 32767.
- Frame 5,6 last, then frame 7,8,9 last -> no output for the first frame; second frame yields {7,8,9} dn_last=1 (no 5/6 leakage).
- Stream 1,2,3,4 with rst pulsed the cycle after 3 is accepted -> no dn_valid after reset, up_ready=0 for one cycle. Coefs back to unity (verify with 4,5,6 last -> {4,5,6}).
- Attempt cfg write mid-frame -> cfg_ready=0 until the frame's last output is emitted, then the write is accepted.

Source files
------------

// File: rtl/group_mult_window.sv
// Sliding-window coefficient multiplier feeding the group adder: GROUP_NB lanes, 3-stage pipeline.
// Optional macro GROUP_MULT_SAT_EN selects saturation instead of wrap in the final scaling stage.
module group_mult_window #(
   parameter int GROUP_NB  = 3,
   parameter int NUM_WIDTH = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [$clog2(GROUP_NB)-1:0]      cfg_addr,
   input  logic signed [NUM_WIDTH-1:0]      cfg_data,
   input  logic signed [NUM_WIDTH-1:0]      up_data,
   input  logic                             up_valid,
   input  logic                             up_last,
   output logic                             up_ready,
   output logic [NUM_WIDTH*GROUP_NB-1:0]    dn_data,
   output logic                             dn_valid,
   output logic                             dn_last
);

   localparam int CW = $clog2(GROUP_NB + 1);
   localparam int PW = 2 * NUM_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(GROUP_NB);
   localparam logic signed [NUM_WIDTH-1:0] UNITY = NUM_WIDTH'(1) << FRAC_BITS;

   if (GROUP_NB < 2) begin : g_bad_group_nb
      initial begin
         $display("group_mult_window: GROUP_NB must be >= 2 (got %0d)", GROUP_NB);
         $finish;
      end
   end

   logic signed [NUM_WIDTH-1:0] win     [GROUP_NB];
   logic signed [NUM_WIDTH-1:0] shifted [GROUP_NB];
   logic signed [NUM_WIDTH-1:0] coef    [GROUP_NB];
   logic signed [NUM_WIDTH-1:0] lane_p0 [GROUP_NB];
   logic signed [PW-1:0]        prod_p1 [GROUP_NB];
   logic [CW-1:0]               cnt;
   logic                        rst_d;
   logic                        vld_p0, last_p0, vld_p1, last_p1;
   logic                        cfg_fire, accept, fills;

   function automatic logic signed [NUM_WIDTH-1:0] scale(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] s;
      s = p >>> FRAC_BITS;
`ifdef GROUP_MULT_SAT_EN
      if (s > $signed({{(NUM_WIDTH+1){1'b0}}, {(NUM_WIDTH-1){1'b1}}}))
         return {1'b0, {(NUM_WIDTH-1){1'b1}}};
      if (s < $signed({{(NUM_WIDTH+1){1'b1}}, {(NUM_WIDTH-1){1'b0}}}))
         return {1'b1, {(NUM_WIDTH-1){1'b0}}};
`endif
      return s[NUM_WIDTH-1:0];
   endfunction

   // Idle means nothing buffered and nothing in flight, so a coefficient change cannot tear a window.
   assign cfg_ready = !rst && (cnt == '0) && !vld_p0 && !vld_p1 && !dn_valid;
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign up_ready  = !rst && !rst_d && !cfg_fire;
   assign accept    = up_valid && up_ready;
   assign fills     = (cnt >= FULL - CW'(1));

   always_comb begin
      for (int i = 0; i < GROUP_NB - 1; i++) shifted[i] = win[i + 1];
      shifted[GROUP_NB-1] = up_data;
   end

   always_ff @(posedge clk) rst_d <= rst;

   // Stage 1: window shift, fill tracking, coefficient writes
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
         for (int i = 0; i < GROUP_NB; i++) begin
            win[i]  <= '0;
            coef[i] <= UNITY;
         end
      end else begin
         vld_p0  <= accept && fills;
         last_p0 <= accept && fills && up_last;
         if (cfg_fire && (int'(cfg_addr) < GROUP_NB)) coef[cfg_addr] <= cfg_data;
         if (accept) begin
            if (up_last) begin
               cnt <= '0;
               for (int i = 0; i < GROUP_NB; i++) win[i] <= '0;
            end else begin
               cnt <= fills ? FULL : cnt + CW'(1);
               for (int i = 0; i < GROUP_NB; i++) win[i] <= shifted[i];
            end
         end
      end
   end

   // The staged copy keeps the closing window of a frame even though win is cleared on that edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < GROUP_NB; i++) lane_p0[i] <= shifted[i];
      end
   end

   // Stage 2: full-width signed products
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= vld_p0;
         last_p1 <= last_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (vld_p0) begin
         for (int i = 0; i < GROUP_NB; i++) prod_p1[i] <= PW'(lane_p0[i]) * PW'(coef[i]);
      end
   end

   // Stage 3: rescale to NUM_WIDTH and present to the adder
   always_ff @(posedge clk) begin
      if (rst) begin
         dn_valid <= 1'b0;
         dn_last  <= 1'b0;
         dn_data  <= '0;
      end else begin
         dn_valid <= vld_p1;
         dn_last  <= last_p1;
         if (vld_p1) begin
            for (int i = 0; i < GROUP_NB; i++) dn_data[i*NUM_WIDTH +: NUM_WIDTH] <= scale(prod_p1[i]);
         end
      end
   end

endmodule

// File: tb/tb_group_mult_window.sv
// Self-checking bench for group_mult_window: fixed vectors, directed corner sequences, random traffic vs a queue model.
module tb_group_mult_window;

   localparam int N = 3;
   localparam int W = 16;
   localparam int F = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  cfg_valid = 1'b0;
   logic                  cfg_ready;
   logic [$clog2(N)-1:0]  cfg_addr = '0;
   logic signed [W-1:0]   cfg_data = '0;
   logic signed [W-1:0]   up_data = '0;
   logic                  up_valid = 1'b0;
   logic                  up_last = 1'b0;
   logic                  up_ready;
   logic [N*W-1:0]        dn_data;
   logic                  dn_valid;
   logic                  dn_last;

   group_mult_window #(.GROUP_NB(N), .NUM_WIDTH(W), .FRAC_BITS(F)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .up_data(up_data), .up_valid(up_valid), .up_last(up_last), .up_ready(up_ready),
      .dn_data(dn_data), .dn_valid(dn_valid), .dn_last(dn_last)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      int             due;
      logic [N*W-1:0] data;
      logic           last;
   } exp_t;

   typedef struct {
      logic signed [W-1:0] smp;
      logic                last;
      logic                exp_v;
      logic [N*W-1:0]      exp_d;
      logic                exp_l;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int stalls = 0;
   int last_out_cyc = -1;
   bit last_acc, last_fire;

   // Reference state: frame samples so far (newest last), coefficients, expected output queue
   logic signed [W-1:0] frame_m[$];
   logic signed [W-1:0] coef_m[N];
   exp_t                q[$];
   logic [N*W-1:0]      dout_m = '0;
   bit                  dv_now = 1'b0;
   bit                  rst_d_m = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   function automatic logic [W-1:0] lane_val(input logic signed [W-1:0] s, input logic signed [W-1:0] c);
      longint p;
      p = longint'(s) * longint'(c);
      p = p >>> F;
`ifdef GROUP_MULT_SAT_EN
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
`endif
      return p[W-1:0];
   endfunction

   task automatic model_accept(input logic signed [W-1:0] s, input logic l);
      exp_t e;
      frame_m.push_back(s);
      if (frame_m.size() >= N) begin
         e.due  = cyc + 2;
         e.last = l;
         for (int i = 0; i < N; i++)
            e.data[i*W +: W] = lane_val(frame_m[frame_m.size() - N + i], coef_m[i]);
         q.push_back(e);
      end
      if (l) frame_m.delete();
   endtask

   task automatic step();
      bit idle, cr_exp, ur_exp, acc, fire, rst_now, exp_v, exp_l;
      #1;
      idle   = (frame_m.size() == 0) && (q.size() == 0) && !dv_now;
      cr_exp = !rst && idle;
      ur_exp = !rst && !rst_d_m && !(cfg_valid && cr_exp);
      chk("cfg_ready", 64'(cfg_ready), 64'(cr_exp));
      chk("up_ready", 64'(up_ready), 64'(ur_exp));
      acc  = up_valid && ur_exp;
      fire = cfg_valid && cr_exp;
      if (up_valid && !ur_exp) stalls++;
      rst_now = rst;
      @(posedge clk);
      #1;
      cyc++;
      rst_d_m   = rst_now;
      last_acc  = acc;
      last_fire = fire;
      if (rst_now) begin
         frame_m.delete();
         q.delete();
         dout_m = '0;
         for (int i = 0; i < N; i++) coef_m[i] = W'(1) << F;
      end else begin
         if (fire && (int'(cfg_addr) < N)) coef_m[cfg_addr] = cfg_data;
         if (acc) model_accept(up_data, up_last);
      end
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      exp_l = 1'b0;
      if (exp_v) begin
         dout_m = q[0].data;
         exp_l  = q[0].last;
         void'(q.pop_front());
         if (exp_l) last_out_cyc = cyc;
      end
      dv_now = exp_v;
      chk("dn_valid", 64'(dn_valid), 64'(exp_v));
      chk("dn_data", 64'(dn_data), 64'(dout_m));
      chk("dn_last", 64'(dn_last), 64'(exp_l));
   endtask

   task automatic send(input logic signed [W-1:0] s, input logic l);
      up_valid = 1'b1;
      up_data  = s;
      up_last  = l;
      for (int t = 0; t < 10; t++) begin
         step();
         if (last_acc) break;
      end
      chk("send_accepted", 64'(last_acc), 64'd1);
      up_valid = 1'b0;
      up_last  = 1'b0;
   endtask

   task automatic wait_out(input string name, input logic [N*W-1:0] d, input logic l);
      bit seen = 1'b0;
      up_valid = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
         step();
         if (dn_valid === 1'b1) begin
            seen = 1'b1;
            chk({name, "_data"}, 64'(dn_data), 64'(d));
            chk({name, "_last"}, 64'(dn_last), 64'(l));
         end
      end
      if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic idle_steps(input int n);
      up_valid = 1'b0;
      for (int t = 0; t < n; t++) step();
   endtask

   vec_t vec[9];
   int   fire_cyc;

   initial begin
      for (int i = 0; i < N; i++) coef_m[i] = W'(1) << F;

      vec[0] = '{16'sd10, 1'b0, 1'b0, '0, 1'b0};
      vec[1] = '{16'sd20, 1'b0, 1'b0, '0, 1'b0};
      vec[2] = '{16'sd30, 1'b0, 1'b1, {16'd30, 16'd20, 16'd10}, 1'b0};
      vec[3] = '{16'sd40, 1'b1, 1'b1, {16'd40, 16'd30, 16'd20}, 1'b1};
      vec[4] = '{16'sd5,  1'b0, 1'b0, '0, 1'b0};
      vec[5] = '{16'sd6,  1'b1, 1'b0, '0, 1'b0};
      vec[6] = '{16'sd7,  1'b0, 1'b0, '0, 1'b0};
      vec[7] = '{16'sd8,  1'b0, 1'b0, '0, 1'b0};
      vec[8] = '{16'sd9,  1'b1, 1'b1, {16'd9, 16'd8, 16'd7}, 1'b1};

      // Reset state, then the post-reset up_ready hole
      rst = 1'b1;
      idle_steps(2);
      chk("rst_dn_data", 64'(dn_data), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_d_up_ready", 64'(up_ready), 64'd0);
      idle_steps(1);

      // Fixed vectors, back-to-back; output of row i is visible after row i+2's edge
      for (int i = 0; i < 11; i++) begin
         if (i < 9) begin
            up_valid = 1'b1;
            up_data  = vec[i].smp;
            up_last  = vec[i].last;
         end else begin
            up_valid = 1'b0;
            up_last  = 1'b0;
         end
         step();
         if (i >= 2) begin
            chk($sformatf("vec%0d_valid", i - 2), 64'(dn_valid), 64'(vec[i-2].exp_v));
            chk($sformatf("vec%0d_last", i - 2), 64'(dn_last), 64'(vec[i-2].exp_l));
            if (vec[i-2].exp_v) chk($sformatf("vec%0d_data", i - 2), 64'(dn_data), 64'(vec[i-2].exp_d));
         end
      end
      idle_steps(2);

      // Config write collides with a sample: write wins, sample stalls one cycle
      stalls    = 0;
      cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = -16'sd512;
      up_valid  = 1'b1; up_data = 16'sd1; up_last = 1'b0;
      step();
      chk("collide_fire", 64'(last_fire), 64'd1);
      chk("collide_no_accept", 64'(last_acc), 64'd0);
      cfg_valid = 1'b0;
      send(16'sd1, 1'b0);
      chk("collide_stall_cycles", 64'(stalls), 64'd1);
      send(16'sd2, 1'b0);
      send(16'sd3, 1'b1);
      wait_out("neg_coef", {16'd3, 16'hFFFC, 16'd1}, 1'b1);
      idle_steps(2);

      // Large coefficient on lane 2: wrap (or saturate)
      cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 16'sh7FFF;
      step();
      cfg_valid = 1'b0;
      send(16'sd0, 1'b0);
      send(16'sd0, 1'b0);
      send(16'sd1000, 1'b1);
`ifdef GROUP_MULT_SAT_EN
      wait_out("big_coef", {16'h7FFF, 16'd0, 16'd0}, 1'b1);
`else
      wait_out("big_coef", {16'hF3FC, 16'd0, 16'd0}, 1'b1);
`endif
      idle_steps(2);

      // Reset one cycle after the window fills: output dropped, coefs back to unity
      send(16'sd1, 1'b0);
      send(16'sd2, 1'b0);
      send(16'sd3, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      up_valid = 1'b1; up_data = 16'sd4; up_last = 1'b0;
      #1;
      chk("post_rst_up_ready", 64'(up_ready), 64'd0);
      step();
      chk("post_rst_no_valid", 64'(dn_valid), 64'd0);
      send(16'sd4, 1'b0);
      send(16'sd5, 1'b0);
      send(16'sd6, 1'b1);
      wait_out("after_rst", {16'd6, 16'd5, 16'd4}, 1'b1);
      idle_steps(2);

      // Config request mid-frame waits until the last output has left
      send(16'sd1, 1'b0);
      send(16'sd2, 1'b0);
      cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 16'sh0200;
      send(16'sd3, 1'b1);
      fire_cyc = -1;
      for (int t = 0; t < 12 && fire_cyc < 0; t++) begin
         step();
         if (last_fire) fire_cyc = cyc - 1;
      end
      cfg_valid = 1'b0;
      chk("midframe_cfg_fire_cycle", 64'(fire_cyc), 64'(last_out_cyc + 1));
      send(16'sd1, 1'b0);
      send(16'sd1, 1'b0);
      send(16'sd1, 1'b1);
      wait_out("new_coef", {16'd1, 16'd1, 16'd2}, 1'b1);
      idle_steps(2);

      // Random traffic against the model
      for (int t = 0; t < 600; t++) begin
         up_valid  = ($urandom_range(0, 3) != 0);
         up_data   = W'($urandom);
         up_last   = ($urandom_range(0, 4) == 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_addr  = 2'($urandom_range(0, 3));
         cfg_data  = W'($urandom);
         rst       = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      cfg_valid = 1'b0;
      idle_steps(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
